// File: rtl/atmega_eep_sync.sv
// atmega_eep_sync
// Streams a whole EEPROM image through the EEPROM external port.
// A load takes bytes from a valid/ready stream and writes them into the EEPROM.
// A save reads the EEPROM and sends the bytes out on a valid/ready stream.
// It also tracks whether the CPU has written the EEPROM since the last load or save.
//
// Ports
//   clk_i, rst_i            : clock; asynchronous active-low reset
//   load_req_i, save_req_i  : one-cycle start requests (load has priority)
//   busy_o, done_o, dirty_o : status
//   ld_data_i/ld_valid_i/ld_ready_o : load stream (sink)
//   sv_data_o/sv_valid_o/sv_ready_i : save stream (source)
//   eep_addr_o, eep_data_o, eep_wr_o, eep_rd_o, eep_en_o : EEPROM port takeover
//   eep_data_i              : EEPROM read data, one cycle after address/rd
//   modified_i              : CPU-write pulse from the EEPROM core
module atmega_eep_sync #(
   parameter int EEP_SIZE = 1024
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_req_i,
   input  logic        save_req_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        dirty_o,
   input  logic [7:0]  ld_data_i,
   input  logic        ld_valid_i,
   output logic        ld_ready_o,
   output logic [7:0]  sv_data_o,
   output logic        sv_valid_o,
   input  logic        sv_ready_i,
   output logic [16:0] eep_addr_o,
   output logic [7:0]  eep_data_o,
   output logic        eep_wr_o,
   output logic        eep_rd_o,
   output logic        eep_en_o,
   input  logic [7:0]  eep_data_i,
   input  logic        modified_i
);

   localparam logic [16:0] LAST = 17'(EEP_SIZE - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_LOAD_WR, S_SAVE_ADDR, S_SAVE_WAIT, S_SAVE_OUT, S_DONE
   } state_t;

   state_t      r_state, w_next;
   logic [16:0] r_cnt, w_cnt_nxt;
   logic        w_last;

   assign w_last     = (r_cnt == LAST);
   assign busy_o     = (r_state != S_IDLE);
   assign ld_ready_o = (r_state == S_LOAD);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_cnt_nxt = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (load_req_i) begin
               w_next    = S_LOAD;
               w_cnt_nxt = '0;
            end else if (save_req_i) begin
               w_next    = S_SAVE_ADDR;
               w_cnt_nxt = '0;
            end
         end
         S_LOAD:      if (ld_valid_i) w_next = S_LOAD_WR;
         S_LOAD_WR: begin
            if (w_last) w_next = S_DONE;
            else begin
               w_next    = S_LOAD;
               w_cnt_nxt = r_cnt + 17'd1;
            end
         end
         S_SAVE_ADDR: w_next = S_SAVE_WAIT;
         S_SAVE_WAIT: w_next = S_SAVE_OUT;
         S_SAVE_OUT: begin
            if (sv_ready_i) begin
               if (w_last) w_next = S_DONE;
               else begin
                  w_next    = S_SAVE_ADDR;
                  w_cnt_nxt = r_cnt + 17'd1;
               end
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs are registered by decoding the next state, so each strobe
   // lines up exactly with the state it belongs to.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         eep_addr_o <= '0;
         eep_data_o <= '0;
         sv_data_o  <= '0;
         sv_valid_o <= 1'b0;
         eep_wr_o   <= 1'b0;
         eep_rd_o   <= 1'b0;
         eep_en_o   <= 1'b0;
         done_o     <= 1'b0;
         dirty_o    <= 1'b0;
      end else begin
         if (r_state == S_LOAD && ld_valid_i) begin
            eep_addr_o <= r_cnt;
            eep_data_o <= ld_data_i;
         end else if (w_next == S_SAVE_ADDR) begin
            eep_addr_o <= w_cnt_nxt;
         end
         if (r_state == S_SAVE_WAIT) sv_data_o <= eep_data_i;
         sv_valid_o <= (w_next == S_SAVE_OUT);
         eep_wr_o   <= (w_next == S_LOAD_WR);
         eep_rd_o   <= (w_next == S_SAVE_ADDR) || (w_next == S_SAVE_WAIT);
         eep_en_o   <= (w_next != S_IDLE) && (w_next != S_DONE);
         done_o     <= (w_next == S_DONE);
         // A CPU write that lands on the DONE-entry edge must not be lost.
         if (modified_i) dirty_o <= 1'b1;
         else if (w_next == S_DONE && r_state != S_DONE) dirty_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_atmega_eep_sync.sv
module tb_atmega_eep_sync;

   logic        clk = 1'b0;
   logic        rst_i, load_req_i, save_req_i, ld_valid_i, sv_ready_i, modified_i;
   logic [7:0]  ld_data_i, eep_data_i;
   logic        busy_o, done_o, dirty_o, ld_ready_o, sv_valid_o;
   logic        eep_wr_o, eep_rd_o, eep_en_o;
   logic [7:0]  sv_data_o, eep_data_o;
   logic [16:0] eep_addr_o;

   always #5 clk = ~clk;

   atmega_eep_sync #(.EEP_SIZE(4)) dut (
      .clk_i(clk), .rst_i(rst_i), .load_req_i(load_req_i), .save_req_i(save_req_i),
      .busy_o(busy_o), .done_o(done_o), .dirty_o(dirty_o),
      .ld_data_i(ld_data_i), .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o),
      .sv_data_o(sv_data_o), .sv_valid_o(sv_valid_o), .sv_ready_i(sv_ready_i),
      .eep_addr_o(eep_addr_o), .eep_data_o(eep_data_o), .eep_wr_o(eep_wr_o),
      .eep_rd_o(eep_rd_o), .eep_en_o(eep_en_o), .eep_data_i(eep_data_i),
      .modified_i(modified_i)
   );

   // EEPROM model: synchronous write, registered read.
   logic [7:0] mem [4];
   logic       pre;
   always @(posedge clk) begin
      if (pre) begin
         mem[0] <= 8'hA0; mem[1] <= 8'hA1; mem[2] <= 8'hA2; mem[3] <= 8'hA3;
      end else if (eep_en_o && eep_wr_o) begin
         mem[eep_addr_o[1:0]] <= eep_data_o;
      end
      eep_data_i <= mem[eep_addr_o[1:0]];
   end

   typedef struct { logic [16:0] a; logic [7:0] d; } wr_t;
   wr_t        wr_q[$];
   logic [7:0] sv_q[$];

   typedef struct {
      logic ld, sv, ldv; logic [7:0] ldd;
      logic busy, rdy, wr, done, en, dirty;
   } vec_t;
   vec_t tbl[13];

   int n_chk = 0, n_fail = 0;
   int done_cnt = 0, popped = 0;
   logic        prev_v = 1'b0;
   logic [7:0]  prev_d;
   logic [16:0] prev_a;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Sample on the falling edge and run the scoreboard/protocol monitor.
   task automatic sample();
      wr_t w;
      logic [7:0] e;
      @(negedge clk);
      check("wr_rd_exclusive", {31'd0, eep_wr_o & eep_rd_o}, 0);
      if (eep_wr_o) begin
         if (wr_q.size() == 0) check("unexpected_write", 1, 0);
         else begin
            w = wr_q.pop_front();
            check("wr_addr", {15'd0, eep_addr_o}, {15'd0, w.a});
            check("wr_data", {24'd0, eep_data_o}, {24'd0, w.d});
         end
      end
      if (sv_valid_o && prev_v) begin
         check("sv_hold_data", {24'd0, sv_data_o}, {24'd0, prev_d});
         check("sv_hold_addr", {15'd0, eep_addr_o}, {15'd0, prev_a});
      end
      if (sv_valid_o && sv_ready_i) begin
         if (sv_q.size() == 0) check("unexpected_save_byte", 1, 0);
         else begin
            e = sv_q.pop_front();
            check("sv_data", {24'd0, sv_data_o}, {24'd0, e});
         end
         popped++;
         prev_v = 1'b0;
      end else begin
         prev_v = sv_valid_o;
      end
      prev_d = sv_data_o;
      prev_a = eep_addr_o;
      if (done_o) done_cnt++;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic run_save(input bit stall, input bit mod_end);
      int st, d0;
      st = 0;
      d0 = done_cnt;
      popped = 0;
      for (int i = 0; i < 4; i++) sv_q.push_back(8'hA0 + 8'(i));
      save_req_i = 1'b1;
      sample(); adv();
      save_req_i = 1'b0;
      for (int c = 0; c < 200 && done_cnt == d0; c++) begin
         sv_ready_i = 1'b1;
         modified_i = 1'b0;
         if (stall && popped == 2 && st < 10) begin
            sv_ready_i = 1'b0;
            if (sv_valid_o) st++;
         end
         if (mod_end && popped == 3 && sv_valid_o) modified_i = 1'b1;
         sample(); adv();
      end
      sv_ready_i = 1'b0;
      modified_i = 1'b0;
      check("save_done_seen", done_cnt, d0 + 1);
      check("save_bytes_left", sv_q.size(), 0);
      if (stall) check("stall_cycles", st, 10);
      for (int c = 0; c < 3; c++) begin sample(); adv(); end
      check("save_done_once", done_cnt, d0 + 1);
      check("save_idle_after", {31'd0, busy_o}, 0);
   endtask

   initial begin
      int d0;
      rst_i = 1'b0; load_req_i = 1'b0; save_req_i = 1'b0; ld_valid_i = 1'b0;
      ld_data_i = 8'h00; sv_ready_i = 1'b0; modified_i = 1'b0; pre = 1'b0;

      // Reset state
      sample();
      check("rst_busy", {31'd0, busy_o}, 0);
      check("rst_done", {31'd0, done_o}, 0);
      check("rst_dirty", {31'd0, dirty_o}, 0);
      check("rst_en", {31'd0, eep_en_o}, 0);
      check("rst_wr_rd", {30'd0, eep_wr_o, eep_rd_o}, 0);
      check("rst_valid_ready", {30'd0, sv_valid_o, ld_ready_o}, 0);
      check("rst_addr", {15'd0, eep_addr_o}, 0);
      check("rst_data", {16'd0, eep_data_o, sv_data_o}, 0);
      adv();
      rst_i = 1'b1;
      adv();

      // Load of 4 bytes; simultaneous load+save picks load, save during LOAD ignored.
      //            ld sv ldv ldd    busy rdy wr done en dirty
      tbl[0]  = '{1'b1,1'b1,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
      tbl[1]  = '{1'b0,1'b0,1'b1,8'h11, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0};
      tbl[2]  = '{1'b0,1'b0,1'b1,8'h22, 1'b1,1'b0,1'b1,1'b0,1'b1,1'b0};
      tbl[3]  = '{1'b0,1'b1,1'b1,8'h22, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0};
      tbl[4]  = '{1'b0,1'b0,1'b1,8'h33, 1'b1,1'b0,1'b1,1'b0,1'b1,1'b0};
      tbl[5]  = '{1'b0,1'b0,1'b1,8'h33, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0};
      tbl[6]  = '{1'b0,1'b0,1'b1,8'h44, 1'b1,1'b0,1'b1,1'b0,1'b1,1'b0};
      tbl[7]  = '{1'b0,1'b0,1'b1,8'h44, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0};
      tbl[8]  = '{1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b1,1'b0,1'b1,1'b0};
      tbl[9]  = '{1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0};
      tbl[10] = '{1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
      tbl[11] = '{1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
      tbl[12] = '{1'b0,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
      wr_q.push_back('{17'd0, 8'h11});
      wr_q.push_back('{17'd1, 8'h22});
      wr_q.push_back('{17'd2, 8'h33});
      wr_q.push_back('{17'd3, 8'h44});
      d0 = done_cnt;
      for (int i = 0; i < 13; i++) begin
         load_req_i = tbl[i].ld; save_req_i = tbl[i].sv;
         ld_valid_i = tbl[i].ldv; ld_data_i = tbl[i].ldd;
         sample();
         check($sformatf("ld%0d_busy", i), {31'd0, busy_o}, {31'd0, tbl[i].busy});
         check($sformatf("ld%0d_ready", i), {31'd0, ld_ready_o}, {31'd0, tbl[i].rdy});
         check($sformatf("ld%0d_wr", i), {31'd0, eep_wr_o}, {31'd0, tbl[i].wr});
         check($sformatf("ld%0d_done", i), {31'd0, done_o}, {31'd0, tbl[i].done});
         check($sformatf("ld%0d_en", i), {31'd0, eep_en_o}, {31'd0, tbl[i].en});
         check($sformatf("ld%0d_dirty", i), {31'd0, dirty_o}, {31'd0, tbl[i].dirty});
         adv();
      end
      load_req_i = 1'b0; save_req_i = 1'b0; ld_valid_i = 1'b0;
      check("load_writes_left", wr_q.size(), 0);
      check("load_done_once", done_cnt, d0 + 1);

      // Preload image, mark dirty, then save with a 10-cycle stall on byte 2.
      pre = 1'b1; adv(); pre = 1'b0;
      modified_i = 1'b1; sample(); adv(); modified_i = 1'b0;
      sample();
      check("dirty_set_idle", {31'd0, dirty_o}, 1);
      adv();
      run_save(1'b1, 1'b0);
      check("dirty_cleared_save", {31'd0, dirty_o}, 0);

      // CPU write on the DONE-entry edge keeps dirty set.
      run_save(1'b0, 1'b1);
      check("dirty_set_wins", {31'd0, dirty_o}, 1);

      // Reset while byte 1 is waiting in SAVE_OUT.
      popped = 0;
      for (int i = 0; i < 4; i++) sv_q.push_back(8'hA0 + 8'(i));
      save_req_i = 1'b1; sample(); adv(); save_req_i = 1'b0;
      for (int c = 0; c < 50; c++) begin
         if (popped == 1 && sv_valid_o) break;
         sv_ready_i = 1'b1;
         sample(); adv();
      end
      sv_ready_i = 1'b0;
      check("mid_save_reached", {31'd0, (popped == 1) && sv_valid_o}, 1);
      sample();
      d0 = done_cnt;
      #2 rst_i = 1'b0;
      #1;
      check("async_rst_busy", {31'd0, busy_o}, 0);
      check("async_rst_valid", {31'd0, sv_valid_o}, 0);
      check("async_rst_en", {31'd0, eep_en_o}, 0);
      sv_q.delete();
      adv(); adv();
      rst_i = 1'b1;
      for (int c = 0; c < 3; c++) begin sample(); adv(); end
      check("rst_no_done", done_cnt, d0);

      // Next save restarts from address 0.
      run_save(1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
